// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types and helpers for the dbus responder and its RAM.
package common;

  typedef logic [31:0] addr_t;
  typedef logic [2:0]  msize_t;   // log2 of the access width in bytes
  typedef logic [7:0]  strobe_t;
  typedef logic [63:0] word_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_resp_state_t;

  function automatic logic [2:0] align_mask(input msize_t size);
    logic [2:0] mask;
    case (size)
      3'd0:    mask = 3'b000;
      3'd1:    mask = 3'b001;
      3'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w, input strobe_t strb);
    word_t res;
    res = old_w;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dbus_responder_ram.sv
// Single-port DEPTH_WORDS x 64 RAM with byte write enables and a registered read port.
module dbus_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    we_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH_WORDS];
  logic [63:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 8; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_responder.sv
// Data-bus slave: one request at a time, LATENCY wait cycles, single-cycle response.
// Optional alignment checking is enabled by defining DBUS_RESPONDER_ALIGN_CHECK_EN.
module dbus_responder
  import common::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       misaligned,
  output logic       busy
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT = 4'(LATENCY);

  dbus_resp_state_t state_q;
  logic [3:0]       cnt_q;
  logic [AW-1:0]    idx_q;
  strobe_t          strobe_q;
  word_t            wdata_q;
  logic             bad_q;
  dbus_resp_t       dresp_q;
  logic             busy_q;

  logic             req_bad_d;
  logic [AW-1:0]    ram_addr_d;
  logic [7:0]       ram_we_d;
  word_t            ram_rdata;
  word_t            resp_data_d;

`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
  logic mis_q;
  assign req_bad_d  = (dreq.addr[2:0] & align_mask(dreq.size)) != 3'b000;
  assign misaligned = mis_q;
`else
  assign req_bad_d  = 1'b0;
  assign misaligned = 1'b0;
`endif

  // The RAM reads the incoming index on the accept edge so data is ready even at LATENCY=0.
  assign ram_addr_d  = (state_q == IDLE) ? dreq.addr[3 +: AW] : idx_q;
  assign ram_we_d    = (state_q == RESP && !rst && !bad_q) ? strobe_q : 8'h00;
  assign resp_data_d = bad_q ? 64'h0 : merge_bytes(ram_rdata, wdata_q, strobe_q);

  dbus_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i   (clk),
    .addr_i  (ram_addr_d),
    .we_i    (ram_we_d),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      strobe_q <= 8'h00;
      wdata_q  <= 64'h0;
      bad_q    <= 1'b0;
      dresp_q  <= '0;
      busy_q   <= 1'b0;
`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      dresp_q <= '0;
      case (state_q)
        IDLE: begin
          if (dreq.valid) begin
            idx_q    <= dreq.addr[3 +: AW];
            strobe_q <= dreq.strobe;
            wdata_q  <= dreq.data;
            bad_q    <= req_bad_d;
            cnt_q    <= LAT;
            busy_q   <= 1'b1;
            state_q  <= (LAT == 4'd0) ? RESP : WAIT;
`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
            mis_q    <= mis_q | req_bad_d;
`endif
          end else begin
            busy_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q  <= cnt_q - 4'd1;
          busy_q <= 1'b1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP: begin
          dresp_q.addr_ok <= 1'b1;
          dresp_q.data_ok <= 1'b1;
          dresp_q.data    <= resp_data_d;
          busy_q          <= 1'b0;
          state_q         <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dresp = dresp_q;
  assign busy  = busy_q;

endmodule
